// File: rtl/bridge_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bridge_pkg : FSM state encoding, command record and bridge addresses  |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
package bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STROBE  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  // One queued command: op bit on top, then address, then write data.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  localparam logic [31:0] ADDR_RESET    = 32'hF000_0000;
  localparam logic [31:0] ADDR_SVC      = 32'hF000_0010;
  localparam logic [31:0] ADDR_DIP      = 32'hF100_0000;
  localparam logic [31:0] ADDR_MOD      = 32'hF200_0000;
  localparam logic [31:0] ADDR_FILTER   = 32'hF300_0000;
  localparam logic [31:0] ADDR_EXT      = 32'hF400_0000;
  localparam logic [31:0] ADDR_NVRAM    = 32'hF500_0000;
  localparam logic [31:0] ADDR_STATUS_L = 32'hFA00_0000;
  localparam logic [31:0] ADDR_STATUS_H = 32'hFB00_0000;

  function automatic cmd_t pack_cmd(input logic write, input logic [31:0] addr,
                                    input logic [31:0] data);
    cmd_t c;
    c.write = write;
    c.addr  = addr;
    c.data  = data;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bridge_cmd_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bridge_cmd_fifo : single-clock first-word-fall-through command FIFO   |
// | Revision        : 1.0                                                 |
// +-----------------------------------------------------------------------+
module bridge_cmd_fifo
  import bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  cmd_t push_cmd,
  input  logic pop,
  output cmd_t head,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // The extra top pointer bit tells a full FIFO apart from an empty one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_cmd;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/bridge_initiator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bridge_initiator : queues commands and issues bridge rd/wr strobes    |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
module bridge_initiator
  import bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [31:0] bridge_addr,
  output logic        bridge_wr,
  output logic [31:0] bridge_wr_data,
  output logic        bridge_rd,
  input  logic [31:0] bridge_rd_data,
  output logic        busy
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_LATENCY - 1);
  // Zero and one gap cycles both spend exactly one cycle in GAP.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ready_en;
  logic             op_write;
  logic             sample;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  cmd_t             head;

  assign cmd_ready = ready_en && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = !fifo_empty || (state != S_IDLE);
  assign bridge_wr = (state == S_STROBE) &&  op_write;
  assign bridge_rd = (state == S_STROBE) && !op_write;

  bridge_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_74a),
    .reset_n  (reset_n),
    .push     (push),
    .push_cmd (pack_cmd(cmd_write, cmd_addr, cmd_data)),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    sample    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        cnt_nxt   = '0;
        state_nxt = op_write ? S_GAP : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt == RD_LAST) begin
          sample    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      ready_en       <= 1'b0;
      op_write       <= 1'b0;
      bridge_addr    <= '0;
      bridge_wr_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ready_en  <= 1'b1;
      rsp_valid <= sample;
      if (sample) rsp_data <= bridge_rd_data;
      // Write data is left untouched by reads so the responder sees it held.
      if (pop) begin
        op_write    <= head.write;
        bridge_addr <= head.addr;
        if (head.write) bridge_wr_data <= head.data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bridge_initiator.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_bridge_initiator : directed self-checking bench for the initiator  |
// | Revision            : 1.0                                             |
// +-----------------------------------------------------------------------+
module tb_bridge_initiator;
  import bridge_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance a: defaults.  Instance b: long read latency.
  logic        a_rst_n, a_cmd_valid, a_cmd_ready, a_cmd_write, a_rsp_valid;
  logic        a_bridge_wr, a_bridge_rd, a_busy;
  logic [31:0] a_cmd_addr, a_cmd_data, a_rsp_data, a_bridge_addr, a_bridge_wr_data;
  logic [31:0] a_bridge_rd_data = '0;
  logic        b_rst_n, b_cmd_valid, b_cmd_ready, b_cmd_write, b_rsp_valid;
  logic        b_bridge_wr, b_bridge_rd, b_busy;
  logic [31:0] b_cmd_addr, b_cmd_data, b_rsp_data, b_bridge_addr, b_bridge_wr_data;
  logic [31:0] b_bridge_rd_data = '0;

  bridge_initiator dut_a (
    .clk_74a(clk), .reset_n(a_rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_write(a_cmd_write), .cmd_addr(a_cmd_addr), .cmd_data(a_cmd_data),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .bridge_addr(a_bridge_addr),
    .bridge_wr(a_bridge_wr), .bridge_wr_data(a_bridge_wr_data), .bridge_rd(a_bridge_rd),
    .bridge_rd_data(a_bridge_rd_data), .busy(a_busy));

  bridge_initiator #(.FIFO_DEPTH(4), .RD_LATENCY(8), .GAP_CYCLES(1)) dut_b (
    .clk_74a(clk), .reset_n(b_rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(b_cmd_write), .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .bridge_addr(b_bridge_addr),
    .bridge_wr(b_bridge_wr), .bridge_wr_data(b_bridge_wr_data), .bridge_rd(b_bridge_rd),
    .bridge_rd_data(b_bridge_rd_data), .busy(b_busy));

  logic [2:0] a_occ;
  assign a_occ = dut_a.u_fifo.wr_ptr - dut_a.u_fifo.rd_ptr;

  function automatic logic [31:0] resp(input logic [31:0] addr);
    return (addr == ADDR_NVRAM) ? 32'h0000_0200 : ~addr;
  endfunction

  // Responder: data appears the cycle after the read strobe and then holds.
  always @(posedge clk) begin
    if (a_bridge_rd) a_bridge_rd_data <= resp(a_bridge_addr);
    if (b_bridge_rd) b_bridge_rd_data <= resp(b_bridge_addr);
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t a_str[$], a_rsp[$], b_str[$], b_rsp[$];
  ev_t ev_a, ev_b, ev_ar, ev_br;
  int  overlap = 0;

  always @(negedge clk) begin
    ev_a  = '{32'(cyc), a_bridge_wr, a_bridge_addr, a_bridge_wr_data};
    ev_b  = '{32'(cyc), b_bridge_wr, b_bridge_addr, b_bridge_wr_data};
    ev_ar = '{32'(cyc), 1'b0, 32'h0, a_rsp_data};
    ev_br = '{32'(cyc), 1'b0, 32'h0, b_rsp_data};
    if (a_bridge_wr || a_bridge_rd) a_str.push_back(ev_a);
    if (b_bridge_wr || b_bridge_rd) b_str.push_back(ev_b);
    if (a_rsp_valid) a_rsp.push_back(ev_ar);
    if (b_rsp_valid) b_rsp.push_back(ev_br);
    if ((a_bridge_wr && a_bridge_rd) || (b_bridge_wr && b_bridge_rd)) overlap <= overlap + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_push(input logic w, input logic [31:0] addr, input logic [31:0] data,
                        output int acc);
    int bud = 0;
    a_cmd_valid = 1'b1; a_cmd_write = w; a_cmd_addr = addr; a_cmd_data = data;
    while (!a_cmd_ready && bud < 40) begin @(negedge clk); bud++; end
    check("a_push_timeout", 32'(bud >= 40), 32'd0);
    acc = cyc;
    @(negedge clk);
    a_cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] baddr [5] = '{ADDR_SVC, ADDR_DIP, ADDR_MOD, ADDR_FILTER, ADDR_EXT};
  int bacc [5];

  initial begin
    int acc, accb, base, rbase, bud;
    a_rst_n = 0; a_cmd_valid = 0; a_cmd_write = 0; a_cmd_addr = '0; a_cmd_data = '0;
    b_rst_n = 0; b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = '0; b_cmd_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cmd_ready", 32'(a_cmd_ready), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_wr_rd", 32'({a_bridge_wr, a_bridge_rd, a_rsp_valid}), 0);
    check("rst_addr", a_bridge_addr, 0);
    check("rst_wr_data", a_bridge_wr_data, 0);
    check("rst_rsp_data", a_rsp_data, 0);
    check("rst_b_ready", 32'(b_cmd_ready), 0);
    a_rst_n = 1; b_rst_n = 1;
    @(negedge clk);
    check("ready_after_rst", 32'(a_cmd_ready), 1);

    // Single write
    a_push(1'b1, ADDR_DIP, 32'h12, acc);
    repeat (6) @(negedge clk);
    check("wr_count", a_str.size(), 1);
    check("wr_cycle", a_str[0].cyc, 32'(acc + 2));
    check("wr_is_wr", 32'(a_str[0].wr), 1);
    check("wr_addr", a_str[0].addr, ADDR_DIP);
    check("wr_data", a_str[0].data, 32'h12);
    check("wr_no_rsp", a_rsp.size(), 0);
    check("wr_busy_done", 32'(a_busy), 0);
    check("addr_held", a_bridge_addr, ADDR_DIP);

    // Single read
    a_push(1'b0, ADDR_NVRAM, 32'hDEAD_BEEF, acc);
    repeat (6) @(negedge clk);
    check("rd_count", a_str.size(), 2);
    check("rd_cycle", a_str[1].cyc, 32'(acc + 2));
    check("rd_is_rd", 32'(a_str[1].wr), 0);
    check("rd_addr", a_str[1].addr, ADDR_NVRAM);
    check("rsp_count", a_rsp.size(), 1);
    check("rsp_cycle", a_rsp[0].cyc, 32'(acc + 4));
    check("rsp_data", a_rsp[0].data, 32'h200);
    check("rsp_data_held", a_rsp_data, 32'h200);
    check("wr_data_kept_on_rd", a_bridge_wr_data, 32'h12);

    // Three back-to-back writes
    a_cmd_valid = 1; a_cmd_write = 1;
    acc = cyc;
    for (int i = 0; i < 3; i++) begin
      a_cmd_addr = ADDR_MOD + 32'(i); a_cmd_data = 32'(i);
      @(negedge clk);
    end
    a_cmd_valid = 0;
    repeat (12) @(negedge clk);
    check("b2b_count", a_str.size(), 5);
    check("b2b_first", a_str[2].cyc, 32'(acc + 2));
    check("b2b_gap1", a_str[3].cyc - a_str[2].cyc, 3);
    check("b2b_gap2", a_str[4].cyc - a_str[3].cyc, 3);
    check("b2b_last_addr", a_str[4].addr, ADDR_MOD + 32'd2);

    // Simultaneous push/pop at occupancy 2, then ten commands through the FIFO
    base = a_str.size();
    a_cmd_valid = 1; a_cmd_write = 1;
    for (int i = 0; i < 3; i++) begin
      a_cmd_addr = ADDR_EXT + 32'(4 * i); a_cmd_data = 32'(100 + i);
      @(negedge clk);
    end
    a_cmd_valid = 0;
    @(negedge clk);
    a_cmd_valid = 1; a_cmd_addr = ADDR_EXT + 32'd12; a_cmd_data = 32'd103;
    check("occ_before_pushpop", 32'(a_occ), 2);
    check("ready_at_occ2", 32'(a_cmd_ready), 1);
    @(negedge clk);
    check("occ_after_pushpop", 32'(a_occ), 2);
    for (int i = 4; i < 10; i++) begin
      a_cmd_addr = ADDR_EXT + 32'(4 * i); a_cmd_data = 32'(100 + i);
      bud = 0;
      while (!a_cmd_ready && bud < 40) begin @(negedge clk); bud++; end
      check("wrap_push_timeout", 32'(bud >= 40), 0);
      @(negedge clk);
    end
    a_cmd_valid = 0;
    repeat (40) @(negedge clk);
    check("wrap_count", a_str.size(), 32'(base + 10));
    for (int i = 0; i < 10; i++) begin
      check("wrap_order", a_str[base + i].addr, ADDR_EXT + 32'(4 * i));
    end
    check("wrap_empty", 32'(a_occ), 0);

    // FIFO fills behind a long read on instance b
    b_cmd_valid = 1; b_cmd_write = 0; b_cmd_addr = ADDR_NVRAM; accb = cyc;
    @(negedge clk);
    b_cmd_valid = 0;
    repeat (2) @(negedge clk);
    b_cmd_valid = 1; b_cmd_write = 1;
    for (int i = 0; i < 5; i++) begin
      b_cmd_addr = baddr[i]; b_cmd_data = 32'(i);
      bud = 0;
      while (!b_cmd_ready && bud < 40) begin @(negedge clk); bud++; end
      bacc[i] = cyc;
      @(negedge clk);
    end
    b_cmd_valid = 0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 4; i++) check("fill_accept", 32'(bacc[i]), 32'(accb + 3 + i));
    check("fifth_accept", 32'(bacc[4]), 32'(accb + 13));
    check("fill_strobes", b_str.size(), 6);
    check("long_rd_cycle", b_str[0].cyc, 32'(accb + 2));
    check("long_rsp_cycle", b_rsp[0].cyc, 32'(accb + 11));
    check("long_rsp_data", b_rsp[0].data, 32'h200);
    for (int i = 0; i < 5; i++) begin
      check("fill_order", b_str[1 + i].addr, baddr[i]);
      check("fill_cycle", b_str[1 + i].cyc, 32'(accb + 13 + 3 * i));
    end

    // Reset during RD_WAIT with two commands queued
    base = a_str.size(); rbase = a_rsp.size();
    a_cmd_valid = 1; a_cmd_write = 0; a_cmd_addr = ADDR_STATUS_H;
    @(negedge clk);
    a_cmd_write = 1; a_cmd_addr = ADDR_STATUS_L;
    @(negedge clk);
    a_cmd_addr = ADDR_RESET;
    @(negedge clk);
    a_cmd_valid = 0;
    check("pre_rst_occ", 32'(a_occ), 2);
    a_rst_n = 0;
    repeat (2) @(negedge clk);
    a_rst_n = 1;
    repeat (10) @(negedge clk);
    check("rst_mid_strobes", a_str.size(), 32'(base + 1));
    check("rst_mid_rd_addr", a_str[base].addr, ADDR_STATUS_H);
    check("rst_mid_no_rsp", a_rsp.size(), 32'(rbase));
    check("rst_mid_busy", 32'(a_busy), 0);
    check("rst_mid_ready", 32'(a_cmd_ready), 1);
    check("rst_mid_rsp_data", a_rsp_data, 0);
    check("no_overlap", 32'(overlap), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bridge_initiator.md
BRIDGE_INITIATOR -- requirements
Module: bridge_initiator

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of queued commands, power of two, minimum 2.
REQ-002 Parameter RD_LATENCY, default 1: cycles from the bridge_rd strobe until bridge_rd_data is valid, minimum 1.
REQ-003 Parameter GAP_CYCLES, default 1: idle cycles after each transaction before the next strobe, minimum 0.
REQ-004 clk_74a  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  32  bridge address.
REQ-010 cmd_data  in  32  write data; ignored for reads.
REQ-011 rsp_valid  out  1  one-cycle pulse: read data returned.
REQ-012 rsp_data  out  32  read data; holds its value until the next rsp_valid.
REQ-013 bridge_addr  out  32  address to the responder.
REQ-014 bridge_wr  out  1  one-cycle write strobe.
REQ-015 bridge_wr_data  out  32  write data to the responder.
REQ-016 bridge_rd  out  1  one-cycle read strobe.
REQ-017 bridge_rd_data  in  32  read data from the responder.
REQ-018 busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-019 Commands shall be queued in order in a FIFO of FIFO_DEPTH entries. cmd_ready shall be low exactly when the FIFO is full.
REQ-020 A push and a pop in the same cycle shall leave the occupancy unchanged. A push while full shall not be possible, because cmd_ready is low.
REQ-021 The FSM shall have four states: IDLE, STROBE, RD_WAIT and GAP.
REQ-022 IDLE: if the FIFO is non-empty, the FSM shall pop the head and load bridge_addr, bridge_wr_data and the op in cycle T-1, then go to STROBE.
REQ-023 STROBE (cycle T): bridge_wr or bridge_rd shall be high for exactly one cycle according to the op. A write shall go to GAP; a read shall go to RD_WAIT.
REQ-024 RD_WAIT: the FSM shall count RD_LATENCY cycles and sample bridge_rd_data on the rising edge ending cycle T+RD_LATENCY.
REQ-025 After that sample, rsp_valid shall be high in cycle T+RD_LATENCY+1 with rsp_data set to the sampled value, and the FSM shall go to GAP.
REQ-026 GAP: the FSM shall stay for GAP_CYCLES cycles and then go to IDLE. With GAP_CYCLES=0 it shall pass through in a single cycle.
REQ-027 bridge_wr and bridge_rd shall never be high in the same cycle.
REQ-028 bridge_addr and bridge_wr_data shall hold their values between transactions.
REQ-029 bridge_wr_data shall not change for reads.
REQ-030 rsp_valid shall never pulse for a write.
REQ-031 An empty FIFO shall produce no strobes, and the FSM shall remain in IDLE.
REQ-032 The FIFO read and write pointers shall wrap modulo FIFO_DEPTH. Full/empty shall be distinguished with an extra pointer bit.
REQ-033 Latency from acceptance of a command into an empty, idle block to its strobe shall be 2 cycles.

Reset
REQ-034 While reset_n is low at a rising edge, the block shall set:
- cmd_ready, bridge_wr, bridge_rd, rsp_valid and busy to 0;
- bridge_addr, bridge_wr_data and rsp_data to 0;
- the FIFO to empty and the FSM to IDLE;
- all counters to 0.
REQ-035 On reset mid-operation, queued commands shall be discarded, and a pending read shall produce no rsp_valid.
REQ-036 cmd_ready shall go high on the first cycle after reset_n returns high.

Structure
REQ-037 Package bridge_pkg shall hold the state enum and the bridge address constants: RESET F0000000, SVC F0000010, DIP F1000000, MOD F2000000, FILTER F3000000, EXT F4000000, NVRAM F5000000, STATUS_L FA000000, STATUS_H FB000000.
REQ-038 The FIFO shall be one sub-module, bridge_cmd_fifo: synchronous, single clock, first-word-fall-through, 65 bits wide (op + addr + data).

Verification
REQ-039 Write F1000000 data 00000012, defaults: bridge_wr high one cycle, 2 cycles after acceptance, with addr F1000000 and data 00000012; rsp_valid stays low.
REQ-040 Read F5000000, with the responder model returning 00000200 one cycle after the strobe: rsp_valid pulses at strobe+2 with rsp_data 00000200.
REQ-041 Hold cmd_valid high with the FSM stalled by a long read (RD_LATENCY=8) so the FIFO fills: cmd_ready goes low after 4 pushes; the 5th command is accepted only after the first pop; all 5 strobes occur in order.
REQ-042 Three back-to-back writes with GAP_CYCLES=1: strobes are 3 cycles apart (strobe, gap, idle/pop); bridge_wr and bridge_rd are never high together.
REQ-043 Reset asserted in the RD_WAIT cycle of a read to FB000000, with 2 commands queued: no rsp_valid and no further strobes; after release, busy=0 and cmd_ready=1.
REQ-044 Push and pop in the same cycle at occupancy 2: occupancy stays 2; pointers wrap correctly over 10 commands.
